// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader and the CPU it feeds.
// Holds the loader FSM state encoding and the default geometry of the
// instruction memory (word address width, bytes per instruction word).
package instr_loader_pkg;

  localparam int DEF_ADDR_W         = 5;
  localparam int DEF_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_RUN      = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Host/memory/CPU-side signal bundle of the program loader.
// Ports: load_start/load_done/byte_in/byte_valid come from the host;
// byte_ready, mem_* (write port), cpu_rst_n, busy, word_count, overflow go out.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) ();

  logic                          load_start;
  logic                          load_done;
  logic [7:0]                    byte_in;
  logic                          byte_valid;
  logic                          byte_ready;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [8*BYTES_PER_WORD-1:0]   mem_wdata;
  logic                          cpu_rst_n;
  logic                          busy;
  logic [ADDR_W:0]               word_count;
  logic                          overflow;

  // loader side
  modport slave (
    input  load_start, load_done, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy,
           word_count, overflow
  );

  // host side
  modport master (
    output load_start, load_done, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy,
           word_count, overflow
  );

endinterface

// File: rtl/instr_loader.sv
// Purpose : assembles host bytes (little-endian) into instruction words and
//           writes them to instruction memory while holding the CPU in reset.
// Latency : last byte of a word accepted at edge N -> mem_we during cycle N+1.
// Backpr. : byte_ready is low in every state but ASSEMBLE, so the host stalls
//           for exactly one cycle per written word.
// Ports   : clk, rst_n (async, active low); bus = instr_loader_if.slave
//           carrying host byte handshake, memory write port and CPU status.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_loader_if.slave  bus
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ld_state_e r_state, w_next_state;

  // datapath state
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [LANE_W-1:0] r_byte_idx,   w_byte_idx_nxt;
  logic [WORD_W-1:0] r_word,       w_word_nxt;
  logic [ADDR_W:0]   r_word_count, w_word_count_nxt;
  logic              r_done_pend,  w_done_pend_nxt;
  logic              r_full,       w_full_nxt;
  logic              r_overflow,   w_overflow_nxt;

  // registered outputs
  logic              r_byte_ready, w_byte_ready_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [WORD_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic              r_cpu_rst_n,  w_cpu_rst_n_nxt;
  logic              r_busy,       w_busy_nxt;

  logic              w_xfer;
  logic              w_last_byte;
  logic [WORD_W-1:0] w_word_fill;

  // r_byte_ready is only ever high in ASSEMBLE, so it also qualifies the state.
  assign w_xfer      = bus.byte_valid & r_byte_ready;
  assign w_last_byte = w_xfer & (r_byte_idx == LAST_LANE);

  // assembly register with the byte of this cycle merged into its lane
  always_comb begin
    w_word_fill = r_word;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (w_xfer && (r_byte_idx == LANE_W'(l))) begin
        w_word_fill[l*8 +: 8] = bus.byte_in;
      end
    end
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_start) w_next_state = ST_ASSEMBLE;
      end
      ST_ASSEMBLE: begin
        if (bus.load_start) begin
          w_next_state = ST_ASSEMBLE;
        end else if (w_last_byte) begin
          w_next_state = ST_WRITE;
        end else if (bus.load_done) begin
          // a byte taken alongside load_done still leaves a partial word
          w_next_state = (w_xfer || (r_byte_idx != '0)) ? ST_WRITE : ST_RUN;
        end
      end
      ST_WRITE: begin
        if (bus.load_start) begin
          w_next_state = ST_ASSEMBLE;
        end else if (r_done_pend || bus.load_done || (r_addr == LAST_ADDR)) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_ASSEMBLE;
        end
      end
      ST_RUN: begin
        if (bus.load_start) w_next_state = ST_ASSEMBLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    w_addr_nxt       = r_addr;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_nxt       = r_word;
    w_word_count_nxt = r_word_count;
    w_done_pend_nxt  = r_done_pend;
    w_full_nxt       = r_full;
    w_overflow_nxt   = r_overflow;

    if (bus.load_start) begin
      // new load or restart: any partial word is dropped
      w_addr_nxt       = '0;
      w_byte_idx_nxt   = '0;
      w_word_nxt       = '0;
      w_word_count_nxt = '0;
      w_done_pend_nxt  = 1'b0;
      w_full_nxt       = 1'b0;
      w_overflow_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ASSEMBLE: begin
          if (w_xfer) begin
            w_word_nxt     = w_word_fill;
            w_byte_idx_nxt = w_last_byte ? '0 : r_byte_idx + 1'b1;
          end
          // remembered across the WRITE cycle that flushes the last word
          if (bus.load_done && (w_next_state == ST_WRITE)) begin
            w_done_pend_nxt = 1'b1;
          end
        end
        ST_WRITE: begin
          w_word_nxt       = '0;
          w_done_pend_nxt  = 1'b0;
          w_word_count_nxt = r_word_count + 1'b1;
          // the last address is never wrapped; full memory ends the load
          if (r_addr == LAST_ADDR) begin
            w_full_nxt = 1'b1;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.byte_valid && r_full) w_overflow_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  // Decoded from the next state so every output comes straight from a flop.
  always_comb begin
    w_byte_ready_nxt = (w_next_state == ST_ASSEMBLE);
    w_mem_we_nxt     = (w_next_state == ST_WRITE);
    w_cpu_rst_n_nxt  = (w_next_state == ST_RUN);
    w_busy_nxt       = (w_next_state == ST_ASSEMBLE) || (w_next_state == ST_WRITE);
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    if (w_next_state == ST_WRITE) begin
      w_mem_addr_nxt  = r_addr;
      w_mem_wdata_nxt = w_word_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_word_count <= '0;
      r_done_pend  <= 1'b0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word       <= w_word_nxt;
      r_word_count <= w_word_count_nxt;
      r_done_pend  <= w_done_pend_nxt;
      r_full       <= w_full_nxt;
      r_overflow   <= w_overflow_nxt;
      r_byte_ready <= w_byte_ready_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_cpu_rst_n  <= w_cpu_rst_n_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  // CPU reset also follows the loader's own reset directly
  assign bus.cpu_rst_n  = r_cpu_rst_n & rst_n;
  assign bus.busy       = r_busy;
  assign bus.word_count = r_word_count;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int AW  = 5;
  localparam int AWS = 2;
  localparam int BPW = DEF_BYTES_PER_WORD;
  localparam int WW  = 8 * BPW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(AW),  .BYTES_PER_WORD(BPW)) m ();
  instr_loader_if #(.ADDR_W(AWS), .BYTES_PER_WORD(BPW)) s ();

  instr_loader #(.ADDR_W(AW),  .BYTES_PER_WORD(BPW)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
  instr_loader #(.ADDR_W(AWS), .BYTES_PER_WORD(BPW)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s));

  int total = 0;
  int bad   = 0;

  int            m_addr_q[$];
  logic [WW-1:0] m_data_q[$];
  int            s_addr_q[$];
  logic [WW-1:0] s_data_q[$];
  int            overlap = 0;
  int            exp_addr_q[$];
  logic [WW-1:0] exp_data_q[$];

  // write monitor
  always @(negedge clk) begin
    if (m.mem_we === 1'b1) begin
      m_addr_q.push_back(int'(m.mem_addr));
      m_data_q.push_back(m.mem_wdata);
      if (m.byte_ready === 1'b1) overlap++;
    end
    if (s.mem_we === 1'b1) begin
      s_addr_q.push_back(int'(s.mem_addr));
      s_data_q.push_back(s.mem_wdata);
    end
  end

  // Reference: bytes grouped BPW at a time, first byte in the low lane,
  // last group zero padded, word k at address k, at most depth words.
  function automatic void build_exp(input logic [7:0] b[$], input int depth);
    int nw;
    exp_addr_q.delete();
    exp_data_q.delete();
    nw = (b.size() + BPW - 1) / BPW;
    if (nw > depth) nw = depth;
    for (int w = 0; w < nw; w++) begin
      logic [WW-1:0] word;
      word = '0;
      for (int j = 0; j < BPW; j++) begin
        if (w * BPW + j < b.size()) word[j*8 +: 8] = b[w * BPW + j];
      end
      exp_addr_q.push_back(w);
      exp_data_q.push_back(word);
    end
  endfunction

  function automatic int count_diffs(input int aq[$], input logic [WW-1:0] dq[$]);
    int n = 0;
    if (aq.size() != exp_addr_q.size()) n++;
    for (int k = 0; k < aq.size() && k < exp_addr_q.size(); k++) begin
      if (aq[k] != exp_addr_q[k] || dq[k] !== exp_data_q[k]) n++;
    end
    return n;
  endfunction

  task automatic clear_writes();
    m_addr_q.delete(); m_data_q.delete();
    s_addr_q.delete(); s_data_q.delete();
    overlap = 0;
  endtask

  task automatic start_load();
    @(negedge clk);
    m.load_start = 1'b1;
    @(negedge clk);
    m.load_start = 1'b0;
    clear_writes();
  endtask

  task automatic pulse_done();
    m.load_done = 1'b1;
    @(negedge clk);
    m.load_done = 1'b0;
  endtask

  // Offers bytes on m; load_done can ride on the cycle the last byte is taken.
  task automatic send_bytes(input logic [7:0] b[$], input bit done_last, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
      m.load_done = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        m.byte_valid = 1'b0;
      end else begin
        m.byte_valid = 1'b1;
        m.byte_in    = b[i];
        if (m.byte_ready === 1'b1) begin
          if (done_last && i == b.size() - 1) m.load_done = 1'b1;
          i++;
        end
      end
    end
    total++;
    if (i != b.size()) begin
      bad++;
      $display("FAIL send_bytes stalled: accepted=%0d required=%0d", i, b.size());
    end
    @(negedge clk);
    m.byte_valid = 1'b0;
    m.load_done  = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int n = 0;
    while (m.cpu_rst_n !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (m.cpu_rst_n === 1'b1);
  endtask

  task automatic check_run_state(input string name, input int exp_wc);
    bit ok;
    wait_run(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL %s run timeout: cpu_rst_n=%b required=1", name, m.cpu_rst_n); end
    total++;
    if (m.busy !== 1'b0) begin bad++; $display("FAIL %s busy: got=%b required=0", name, m.busy); end
    total++;
    if (m.word_count !== (AW+1)'(exp_wc)) begin
      bad++; $display("FAIL %s word_count: got=%0d required=%0d", name, m.word_count, exp_wc);
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (m.cpu_rst_n  !== 1'b0) begin bad++; $display("FAIL reset cpu_rst_n: got=%b required=0", m.cpu_rst_n); end
    total++; if (m.mem_we     !== 1'b0) begin bad++; $display("FAIL reset mem_we: got=%b required=0", m.mem_we); end
    total++; if (m.byte_ready !== 1'b0) begin bad++; $display("FAIL reset byte_ready: got=%b required=0", m.byte_ready); end
    total++; if (m.busy       !== 1'b0) begin bad++; $display("FAIL reset busy: got=%b required=0", m.busy); end
    total++; if (m.mem_addr   !== '0)   begin bad++; $display("FAIL reset mem_addr: got=%h required=0", m.mem_addr); end
    total++; if (m.mem_wdata  !== '0)   begin bad++; $display("FAIL reset mem_wdata: got=%h required=0", m.mem_wdata); end
    total++; if (m.word_count !== '0)   begin bad++; $display("FAIL reset word_count: got=%0d required=0", m.word_count); end
    total++; if (m.overflow   !== 1'b0) begin bad++; $display("FAIL reset overflow: got=%b required=0", m.overflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m.byte_ready !== 1'b0) begin bad++; $display("FAIL idle byte_ready: got=%b required=0", m.byte_ready); end
    total++; if (m.cpu_rst_n  !== 1'b0) begin bad++; $display("FAIL idle cpu_rst_n: got=%b required=0", m.cpu_rst_n); end
  endtask

  task automatic test_single_word();
    logic [7:0] b[$];
    start_load();
    total++; if (m.busy !== 1'b1) begin bad++; $display("FAIL single busy: got=%b required=1", m.busy); end
    b.push_back(8'h13); b.push_back(8'h00); b.push_back(8'h50); b.push_back(8'h00);
    send_bytes(b, 1'b0, 1'b0);
    pulse_done();
    check_run_state("single", 1);
    total++;
    if (m_addr_q.size() != 1 || m_addr_q[0] != 0 || m_data_q[0] !== 32'h00500013) begin
      bad++;
      $display("FAIL single write: writes=%0d addr=%0d data=%h required 1 write addr 0 data 00500013",
               m_addr_q.size(), (m_addr_q.size() > 0) ? m_addr_q[0] : -1,
               (m_data_q.size() > 0) ? m_data_q[0] : '0);
    end
  endtask

  task automatic test_partial_word();
    logic [7:0] b[$];
    start_load();
    b.push_back(8'hAA); b.push_back(8'hBB);
    send_bytes(b, 1'b0, 1'b0);
    pulse_done();
    check_run_state("partial", 1);
    total++;
    if (m_addr_q.size() != 1 || m_addr_q[0] != 0 || m_data_q[0] !== 32'h0000BBAA) begin
      bad++;
      $display("FAIL partial write: writes=%0d data=%h required 1 write data 0000bbaa",
               m_addr_q.size(), (m_data_q.size() > 0) ? m_data_q[0] : '0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    int d;
    start_load();
    for (int k = 0; k < 8; k++) b.push_back(8'($urandom_range(0, 255)));
    send_bytes(b, 1'b1, 1'b0);
    check_run_state("b2b", 2);
    build_exp(b, 1 << AW);
    d = count_diffs(m_addr_q, m_data_q);
    total++;
    if (d !== 0) begin bad++; $display("FAIL b2b writes: diffs=%0d got=%0d writes required=%0d", d, m_addr_q.size(), exp_addr_q.size()); end
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL b2b byte_ready during write: got=%0d cycles required=0", overlap); end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] b[$];
      int n, d;
      bit done_last;
      start_load();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
      done_last = 1'($urandom_range(0, 1));
      send_bytes(b, done_last, 1'b1);
      if (!done_last) pulse_done();
      build_exp(b, 1 << AW);
      check_run_state("random", exp_addr_q.size());
      d = count_diffs(m_addr_q, m_data_q);
      total++;
      if (d !== 0) begin
        bad++;
        $display("FAIL random load %0d (%0d bytes): diffs=%0d got=%0d writes required=%0d",
                 it, n, d, m_addr_q.size(), exp_addr_q.size());
      end
      total++;
      if (overlap !== 0) begin bad++; $display("FAIL random byte_ready during write: got=%0d required=0", overlap); end
    end
  endtask

  task automatic test_run_restart();
    logic [7:0] b[$];
    int d;
    @(negedge clk);
    total++; if (m.cpu_rst_n !== 1'b1) begin bad++; $display("FAIL restart pre cpu_rst_n: got=%b required=1", m.cpu_rst_n); end
    m.load_start = 1'b1;
    @(negedge clk);
    m.load_start = 1'b0;
    clear_writes();
    total++; if (m.cpu_rst_n  !== 1'b0) begin bad++; $display("FAIL restart cpu_rst_n: got=%b required=0", m.cpu_rst_n); end
    total++; if (m.word_count !== '0)   begin bad++; $display("FAIL restart word_count: got=%0d required=0", m.word_count); end
    total++; if (m.byte_ready !== 1'b1) begin bad++; $display("FAIL restart byte_ready: got=%b required=1", m.byte_ready); end
    for (int k = 0; k < 4; k++) b.push_back(8'($urandom_range(0, 255)));
    send_bytes(b, 1'b1, 1'b0);
    check_run_state("restart", 1);
    build_exp(b, 1 << AW);
    d = count_diffs(m_addr_q, m_data_q);
    total++;
    if (d !== 0) begin bad++; $display("FAIL restart writes: diffs=%0d got=%0d writes required=%0d", d, m_addr_q.size(), exp_addr_q.size()); end
  endtask

  task automatic test_restart_mid_load();
    logic [7:0] old_b[$];
    logic [7:0] b[$];
    int d;
    start_load();
    for (int k = 0; k < 3; k++) old_b.push_back(8'($urandom_range(0, 255)));
    send_bytes(old_b, 1'b0, 1'b0);
    start_load();
    for (int k = 0; k < 4; k++) b.push_back(8'($urandom_range(0, 255)));
    send_bytes(b, 1'b1, 1'b1);
    check_run_state("midrestart", 1);
    build_exp(b, 1 << AW);
    d = count_diffs(m_addr_q, m_data_q);
    total++;
    if (d !== 0) begin bad++; $display("FAIL midrestart writes: diffs=%0d got=%0d writes required=%0d", d, m_addr_q.size(), exp_addr_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b[$];
    int d;
    start_load();
    b.push_back(8'($urandom_range(0, 255)));
    b.push_back(8'($urandom_range(0, 255)));
    send_bytes(b, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (m.byte_ready !== 1'b0) begin bad++; $display("FAIL rstmid byte_ready: got=%b required=0", m.byte_ready); end
    total++; if (m.busy       !== 1'b0) begin bad++; $display("FAIL rstmid busy: got=%b required=0", m.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m_addr_q.size() != 0) begin bad++; $display("FAIL rstmid stray write: got=%0d writes required=0", m_addr_q.size()); end
    start_load();
    b.delete();
    for (int k = 0; k < 4; k++) b.push_back(8'($urandom_range(0, 255)));
    send_bytes(b, 1'b1, 1'b0);
    check_run_state("rstmid", 1);
    build_exp(b, 1 << AW);
    d = count_diffs(m_addr_q, m_data_q);
    total++;
    if (d !== 0) begin bad++; $display("FAIL rstmid writes: diffs=%0d got=%0d writes required=%0d", d, m_addr_q.size(), exp_addr_q.size()); end
  endtask

  task automatic test_full_memory();
    logic [7:0] b[$];
    int i = 0;
    int n = 0;
    int d;
    @(negedge clk);
    s.load_start = 1'b1;
    @(negedge clk);
    s.load_start = 1'b0;
    clear_writes();
    for (int k = 0; k < 16; k++) b.push_back(8'($urandom_range(0, 255)));
    while (i < b.size() && n < 500) begin
      s.byte_valid = 1'b1;
      s.byte_in    = b[i];
      if (s.byte_ready === 1'b1) i++;
      @(negedge clk);
      n++;
    end
    s.byte_valid = 1'b0;
    n = 0;
    while (s.cpu_rst_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++; if (s.cpu_rst_n  !== 1'b1) begin bad++; $display("FAIL full auto run: cpu_rst_n=%b required=1", s.cpu_rst_n); end
    total++; if (s.word_count !== 3'd4) begin bad++; $display("FAIL full word_count: got=%0d required=4", s.word_count); end
    total++; if (s.overflow   !== 1'b0) begin bad++; $display("FAIL full early overflow: got=%b required=0", s.overflow); end
    build_exp(b, 1 << AWS);
    d = count_diffs(s_addr_q, s_data_q);
    total++;
    if (d !== 0) begin bad++; $display("FAIL full writes: diffs=%0d got=%0d writes required=%0d", d, s_addr_q.size(), exp_addr_q.size()); end
    // one byte beyond capacity
    s.byte_valid = 1'b1;
    s.byte_in    = 8'($urandom_range(0, 255));
    @(negedge clk);
    s.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (s.overflow !== 1'b1) begin bad++; $display("FAIL full overflow: got=%b required=1", s.overflow); end
    total++; if (s_addr_q.size() != 4) begin bad++; $display("FAIL full extra write: got=%0d writes required=4", s_addr_q.size()); end
    total++; if (s.cpu_rst_n !== 1'b1) begin bad++; $display("FAIL full run kept: cpu_rst_n=%b required=1", s.cpu_rst_n); end
  endtask

  initial begin
    m.load_start = 1'b0; m.load_done = 1'b0; m.byte_valid = 1'b0; m.byte_in = 8'h00;
    s.load_start = 1'b0; s.load_done = 1'b0; s.byte_valid = 1'b0; s.byte_in = 8'h00;
    test_reset();
    test_single_word();
    test_partial_word();
    test_back_to_back();
    test_random_loads();
    test_run_restart();
    test_restart_mid_load();
    test_reset_mid_load();
    test_full_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
